// File: rtl/permute_controller.sv
// Sequencing FSM for the permute datapath: drives the file-reader load, line/cell counters and writer enable,
// with start/busy/done handshake, writer back-pressure, user abort and a stall watchdog.
module permute_controller #(
    parameter int unsigned STALL_MAX = 1024,
    parameter int unsigned STALL_W   = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic fw_ready,
    input  logic co_c64,
    input  logic co_c25,
    output logic ld_fr,
    output logic en_fw,
    output logic init0_c64,
    output logic init0_c25,
    output logic en_c64,
    output logic en_c25,
    output logic busy,
    output logic done,
    output logic aborted,
    output logic stall_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_PERM,
        S_NEXT,
        S_DONE,
        S_ABORT
    } state_t;

    state_t               state_q, state_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic [STALL_W-1:0]   stall_inc;
    logic                 stall_trip;
    logic                 stall_err_q, stall_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            stall_q     <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_q     <= stall_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign stall_inc  = stall_q + STALL_W'(1);
    assign stall_trip = (stall_inc >= STALL_W'(STALL_MAX));

    // Next-state and strobe decode; abort suppresses every datapath strobe in its cycle.
    always_comb begin
        state_d     = state_q;
        stall_d     = '0;
        stall_err_d = stall_err_q;
        ld_fr       = 1'b0;
        en_fw       = 1'b0;
        init0_c64   = 1'b0;
        init0_c25   = 1'b0;
        en_c64      = 1'b0;
        en_c25      = 1'b0;
        done        = 1'b0;
        aborted     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_INIT;
                    stall_err_d = 1'b0;
                end
            end
            S_INIT: begin
                init0_c64 = 1'b1;
                init0_c25 = 1'b1;
                state_d   = abort ? S_ABORT : S_LOAD;
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else begin
                    ld_fr   = 1'b1;
                    state_d = S_PERM;
                end
            end
            S_PERM: begin
                if (fw_ready) begin
                    if (abort) begin
                        state_d = S_ABORT;
                    end else begin
                        en_fw  = 1'b1;
                        en_c25 = 1'b1;
                        if (co_c25) begin
                            state_d = S_NEXT;
                        end
                    end
                end else begin
                    stall_d = stall_trip ? STALL_W'(STALL_MAX) : stall_inc;
                    if (stall_trip) begin
                        stall_err_d = 1'b1;
                        state_d     = S_ABORT;
                    end
                    if (abort) begin
                        state_d = S_ABORT;
                    end
                end
            end
            S_NEXT: begin
                init0_c25 = 1'b1;
                if (abort) begin
                    state_d = S_ABORT;
                end else if (co_c64) begin
                    state_d = S_DONE;
                end else begin
                    en_c64  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                init0_c64 = 1'b1;
                init0_c25 = 1'b1;
                aborted   = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign stall_err = stall_err_q;

endmodule

// File: tb/tb_permute_controller.sv
// Bench for permute_controller: a counter model stands in for the datapath, and run timing is
// predicted from the fw_ready schedule with plain line/cell arithmetic.
module tb_permute_controller;

    logic clk = 1'b0;
    logic rst, start, abort, fw_ready;
    logic co_c64, co_c25;
    logic ld_fr, en_fw, init0_c64, init0_c25, en_c64, en_c25;
    logic busy, done, aborted, stall_err;

    int checks   = 0;
    int failures = 0;

    permute_controller #(.STALL_MAX(8), .STALL_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .fw_ready  (fw_ready),
        .co_c64    (co_c64),
        .co_c25    (co_c25),
        .ld_fr     (ld_fr),
        .en_fw     (en_fw),
        .init0_c64 (init0_c64),
        .init0_c25 (init0_c25),
        .en_c64    (en_c64),
        .en_c25    (en_c25),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .stall_err (stall_err)
    );

    always #5 clk = ~clk;

    // Datapath counters as the controller's strobes would drive them.
    int c25 = 0;
    int c64 = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            c25 <= 0;
            c64 <= 0;
        end else begin
            if (init0_c25)   c25 <= 0;
            else if (en_c25) c25 <= c25 + 1;
            if (init0_c64)   c64 <= 0;
            else if (en_c64) c64 <= c64 + 1;
        end
    end
    assign co_c25 = (c25 == 24);
    assign co_c64 = (c64 == 63);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Cumulative event monitor sampled mid-cycle.
    int n_fw = 0, n_c64 = 0, n_ld = 0, n_done = 0, n_ab = 0, n_viol = 0;
    int done_cyc = 0, ab_cyc = 0;
    logic [1:0] ab_init = 2'b00;
    logic       ab_serr = 1'b0;
    always @(negedge clk) begin
        if (en_fw)  n_fw++;
        if (en_c64) n_c64++;
        if (ld_fr)  n_ld++;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (aborted) begin
            n_ab++;
            ab_cyc  = cyc;
            ab_init = {init0_c64, init0_c25};
            ab_serr = stall_err;
        end
        if ((en_fw && !fw_ready) || (en_c25 != en_fw) ||
            (abort && (en_fw || en_c25 || en_c64 || ld_fr)))
            n_viol++;
    end

    logic rdy [4096];
    int   abort_e;
    logic hold_start;
    int   base;
    int   end_rel;
    int   s_fw, s_c64, s_ld, s_done, s_ab, s_viol;

    function automatic logic [9:0] outs();
        return {ld_fr, en_fw, init0_c64, init0_c25, en_c64, en_c25, busy, done, aborted, stall_err};
    endfunction

    // Relative edge at which DONE is entered, from line/cell bookkeeping over the ready schedule.
    function automatic int exp_done_rel();
        int e = 2;
        for (int line = 0; line < 64; line++) begin
            int cells = 0;
            e++;
            while (cells < 25 && e < 4095) begin
                if (rdy[e]) cells++;
                e++;
            end
            e++;
        end
        return e;
    endfunction

    task automatic snap();
        s_fw = n_fw; s_c64 = n_c64; s_ld = n_ld;
        s_done = n_done; s_ab = n_ab; s_viol = n_viol;
    endtask

    // Issue start, then feed fw_ready/abort per relative edge until the FSM returns to IDLE.
    task automatic do_run(input string name, input int budget);
        bit finished = 0;
        int r;
        snap();
        @(posedge clk); #1;
        start    = 1'b1;
        base     = cyc;
        fw_ready = rdy[0];
        end_rel  = -1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            r = cyc - base;
            if (!hold_start) start = 1'b0;
            fw_ready = (r < 4096) ? rdy[r] : 1'b1;
            abort    = (r == abort_e);
            if (!busy) begin
                finished = 1;
                end_rel  = r;
                break;
            end
        end
        abort = 1'b0;
        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic fill_ready(input int low_from);
        for (int i = 0; i < 4096; i++) rdy[i] = (i < low_from);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; fw_ready = 1'b0; hold_start = 1'b0; abort_e = -1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs() !== 10'b0) begin
            failures++;
            $display("FAIL reset_outs: got %b required %b", outs(), 10'b0);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (outs() !== 10'b0) begin
                failures++;
                $display("FAIL idle_outs: cycle %0d got %b required %b", i, outs(), 10'b0);
            end
        end
    endtask

    task automatic test_full_run(input string name);
        fill_ready(4096);
        abort_e = -1;
        do_run(name, 2000);
        checks++; if (n_fw - s_fw !== 1600) begin failures++; $display("FAIL %s_en_fw: got %0d required 1600", name, n_fw - s_fw); end
        checks++; if (n_c64 - s_c64 !== 63) begin failures++; $display("FAIL %s_en_c64: got %0d required 63", name, n_c64 - s_c64); end
        checks++; if (n_ld - s_ld !== 64) begin failures++; $display("FAIL %s_ld_fr: got %0d required 64", name, n_ld - s_ld); end
        checks++; if (n_done - s_done !== 1) begin failures++; $display("FAIL %s_done_cnt: got %0d required 1", name, n_done - s_done); end
        checks++; if (done_cyc - base !== 1730) begin failures++; $display("FAIL %s_done_edge: got %0d required 1730", name, done_cyc - base); end
        checks++; if (end_rel !== 1731) begin failures++; $display("FAIL %s_busy_low: got %0d required 1731", name, end_rel); end
        checks++; if (n_ab - s_ab !== 0) begin failures++; $display("FAIL %s_aborted: got %0d required 0", name, n_ab - s_ab); end
        checks++; if (stall_err !== 1'b0) begin failures++; $display("FAIL %s_stall_err: got %b required 0", name, stall_err); end
    endtask

    task automatic test_fw_random();
        int lowrun = 0;
        int exp_rel;
        for (int i = 0; i < 4096; i++) begin
            rdy[i] = ($urandom_range(0, 2) != 0) || (lowrun >= 5);
            lowrun = rdy[i] ? 0 : lowrun + 1;
        end
        exp_rel = exp_done_rel();
        abort_e = -1;
        do_run("random", 4000);
        checks++; if (n_fw - s_fw !== 1600) begin failures++; $display("FAIL random_en_fw: got %0d required 1600", n_fw - s_fw); end
        checks++; if (n_viol - s_viol !== 0) begin failures++; $display("FAIL random_gating: got %0d bad strobes required 0", n_viol - s_viol); end
        checks++; if (done_cyc - base !== exp_rel) begin failures++; $display("FAIL random_done_edge: got %0d required %0d", done_cyc - base, exp_rel); end
        checks++; if (n_c64 - s_c64 !== 63) begin failures++; $display("FAIL random_en_c64: got %0d required 63", n_c64 - s_c64); end
        checks++; if (stall_err !== 1'b0) begin failures++; $display("FAIL random_stall_err: got %b required 0", stall_err); end
    endtask

    // Line 5 cell 3 is relative edge 2 + 27*5 + 1 + 3 = 141; eight low cycles trip at 148.
    task automatic test_watchdog(input string name, input int ab_at);
        fill_ready(141);
        abort_e = ab_at;
        do_run(name, 400);
        checks++; if (ab_cyc - base !== 149) begin failures++; $display("FAIL %s_abort_edge: got %0d required 149", name, ab_cyc - base); end
        checks++; if (n_ab - s_ab !== 1) begin failures++; $display("FAIL %s_abort_cnt: got %0d required 1", name, n_ab - s_ab); end
        checks++; if (ab_serr !== 1'b1) begin failures++; $display("FAIL %s_stall_err: got %b required 1", name, ab_serr); end
        checks++; if (ab_init !== 2'b11) begin failures++; $display("FAIL %s_init0: got %b required 11", name, ab_init); end
        checks++; if (n_done - s_done !== 0) begin failures++; $display("FAIL %s_done: got %0d required 0", name, n_done - s_done); end
        checks++; if (n_fw - s_fw !== 128) begin failures++; $display("FAIL %s_en_fw: got %0d required 128", name, n_fw - s_fw); end
        checks++; if (end_rel !== 150) begin failures++; $display("FAIL %s_idle_edge: got %0d required 150", name, end_rel); end
        checks++; if (stall_err !== 1'b1) begin failures++; $display("FAIL %s_sticky: got %b required 1", name, stall_err); end
    endtask

    // NEXT of line 10 is relative edge 2 + 27*10 + 26 = 298.
    task automatic test_abort_next();
        fill_ready(4096);
        abort_e = 298;
        do_run("abort_next", 400);
        checks++; if (n_c64 - s_c64 !== 10) begin failures++; $display("FAIL abort_next_en_c64: got %0d required 10", n_c64 - s_c64); end
        checks++; if (n_ld - s_ld !== 11) begin failures++; $display("FAIL abort_next_ld_fr: got %0d required 11", n_ld - s_ld); end
        checks++; if (ab_cyc - base !== 299) begin failures++; $display("FAIL abort_next_edge: got %0d required 299", ab_cyc - base); end
        checks++; if (n_done - s_done !== 0) begin failures++; $display("FAIL abort_next_done: got %0d required 0", n_done - s_done); end
        checks++; if (n_fw - s_fw !== 275) begin failures++; $display("FAIL abort_next_en_fw: got %0d required 275", n_fw - s_fw); end
        checks++; if (n_viol - s_viol !== 0) begin failures++; $display("FAIL abort_next_suppress: got %0d bad strobes required 0", n_viol - s_viol); end
        checks++; if (stall_err !== 1'b0) begin failures++; $display("FAIL abort_next_clear: got %b required 0", stall_err); end
        checks++; if (end_rel !== 300) begin failures++; $display("FAIL abort_next_idle: got %0d required 300", end_rel); end
    endtask

    task automatic test_start_held_reset();
        fill_ready(4096);
        abort_e    = -1;
        hold_start = 1'b1;
        do_run("held", 2000);
        checks++; if (done_cyc - base !== 1730) begin failures++; $display("FAIL held_done_edge: got %0d required 1730", done_cyc - base); end
        checks++; if (n_done - s_done !== 1) begin failures++; $display("FAIL held_done_cnt: got %0d required 1", n_done - s_done); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL held_restart: busy got %b required 1", busy); end
        // Restart edge is new edge 1; PERM cell 12 falls at new edge 15.
        repeat (14) @(posedge clk);
        #3;
        checks++; if (en_fw !== 1'b1) begin failures++; $display("FAIL held_in_perm: en_fw got %b required 1", en_fw); end
        rst = 1'b1;
        #1;
        checks++; if (outs() !== 10'b0) begin failures++; $display("FAIL async_rst_outs: got %b required %b", outs(), 10'b0); end
        hold_start = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (outs() !== 10'b0) begin failures++; $display("FAIL post_rst_idle: got %b required %b", outs(), 10'b0); end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if ({busy, init0_c64, init0_c25} !== 3'b111) begin failures++; $display("FAIL second_start: got %b required 111", {busy, init0_c64, init0_c25}); end
        @(posedge clk); #1;
        checks++; if (ld_fr !== 1'b1) begin failures++; $display("FAIL second_load: ld_fr got %b required 1", ld_fr); end
    endtask

    initial begin
        test_reset();
        test_full_run("full");
        test_fw_random();
        test_watchdog("watchdog", -1);
        test_abort_next();
        test_full_run("rerun");
        test_watchdog("trip_abort", 148);
        test_start_held_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/permute_controller.md
Name: permute_controller

Overview:
- Sequencing FSM for the permute datapath. It drives the file-reader load, the 64-line and 25-cell counters, and the file-writer enable.
- It adds a start/busy/done handshake, writer back-pressure (fw_ready), a user abort, and a stall watchdog.
- It sits between the top-level encoder control and the permute datapath, and consumes the datapath's co_c64 and co_c25.

Parameters:
STALL_MAX, 1024, consecutive fw_ready-low cycles in PERM before the watchdog trips (must be >= 1).
STALL_W, 11, width of the stall counter (must hold STALL_MAX).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  start request, sampled only in IDLE
abort  input  1  cancel request, honoured in any non-IDLE state
fw_ready  input  1  file writer can accept a cell this cycle
co_c64  input  1  line counter at last line (63)
co_c25  input  1  cell counter at last cell (24)
ld_fr  output  1  load current line into file reader
en_fw  output  1  write current permuted cell
init0_c64  output  1  clear line counter
init0_c25  output  1  clear cell counter
en_c64  output  1  advance line counter and file reader
en_c25  output  1  advance cell counter
busy  output  1  state != IDLE
done  output  1  one-cycle pulse, permutation complete
aborted  output  1  one-cycle pulse, run ended by abort or watchdog
stall_err  output  1  sticky, watchdog tripped; cleared on next accepted start

Behaviour:
- Reset (async): state=IDLE, stall counter=0, stall_err=0. All outputs 0.
- States: IDLE, INIT, LOAD, PERM, NEXT, DONE, ABORT.
- Outputs are decoded from state. en_fw and en_c25 are additionally gated by fw_ready.
- IDLE: all strobes 0. If start=1 -> INIT, and stall_err clears.
- INIT (1 cycle): init0_c64=1, init0_c25=1 -> LOAD.
- LOAD (1 cycle): ld_fr=1 -> PERM.
- PERM, fw_ready=1:
  - en_fw=1, en_c25=1, stall counter=0.
  - If co_c25=1 (cell 24 written this cycle) -> NEXT, else stay.
- PERM, fw_ready=0:
  - en_fw=0, en_c25=0; stall counter increments.
  - When it reaches STALL_MAX: stall_err<=1 -> ABORT.
- NEXT (1 cycle): init0_c25=1.
  - If co_c64=1 -> DONE.
  - Else en_c64=1 -> LOAD.
- DONE (1 cycle): done=1 -> IDLE.
- ABORT (1 cycle): init0_c64=1, init0_c25=1, aborted=1 -> IDLE. done stays 0.
- Abort precedence: abort=1 in INIT/LOAD/PERM/NEXT -> ABORT next cycle.
  - In that cycle all strobes are suppressed (en_fw, en_c25, en_c64, ld_fr = 0).
  - abort in DONE is ignored (run already complete).
  - abort in ABORT or IDLE has no effect.
- start while busy is ignored; it is not queued.
- Simultaneous watchdog trip and abort: single ABORT, stall_err=1.
- Stall counter saturates at STALL_MAX and resets in every state other than PERM.
- Timing, fw_ready constantly 1:
  - Each line costs 27 cycles (LOAD 1 + PERM 25 + NEXT 1).
  - The start-sampling edge enters INIT; DONE is entered at edge 1 + 64*27 + 1 = 1730.
- Exactly 1600 en_fw pulses per complete run, and exactly 63 en_c64 pulses.
- Reset mid-run: immediate return to IDLE with all outputs 0. The datapath counters are reset by the same rst.

Test Plan:
- Reset then idle, start=0 for 20 cycles -> all outputs 0, busy=0.
- start pulse with fw_ready=1 -> busy high; ld_fr pulses 64 times; en_fw high 1600 cycles; done single pulse at edge 1730; busy low the next cycle.
- fw_ready toggled 0/1 every cycle in PERM -> en_fw count still 1600, no en_fw while fw_ready=0, done delayed accordingly, stall_err=0.
- STALL_MAX=8, fw_ready held 0 from line 5 cell 3 -> ABORT after 8 low cycles; aborted pulse; stall_err=1; init0_c64/init0_c25 high 1 cycle; done never asserts.
- abort asserted in NEXT of line 10 -> no en_c64 that cycle; ABORT then IDLE. New start clears stall_err and gives a full 1600-write run.
- start held high through run plus async rst at PERM cycle 12 -> outputs 0 immediately; second start after release is accepted only in IDLE.
